gen_reg_fifo_param: RTL and testbench

GEN_REG_FIFO_PARAM -- requirements
Module: gen_reg_fifo_param

---
 rtl/gen_fifo_pkg.sv | 18 +
 rtl/gen_fifo_ctrl.sv | 86 ++++++++
 rtl/gen_reg_fifo_param.sv | 91 +++++++++
 tb/tb_gen_reg_fifo_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gen_fifo_pkg.sv
// Shared constants and helpers for the generic register-array FIFO family.
// Fixed-size wrappers pick their geometry from the defaults here.
package gen_fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned DEFAULT_WIDTH = 28;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gen_fifo_ctrl.sv
// Pointer, occupancy, flag and sticky-error bookkeeping for the register FIFO.
// Storage and the read data path live in the enclosing FIFO.
module gen_fifo_ctrl
  import gen_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic          err_clear,
  input  logic [AW:0]   af_threshold,
  input  logic [AW:0]   ae_threshold,
  output logic          wr_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   depth,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overrun,
  output logic          underrun,
  output logic [AW:0]   high_water
);

  localparam logic [AW:0] DEPTH_FULL = (AW + 1)'(DEPTH);

  logic          push_ok;
  logic          pop_ok;
  logic          overrun_set;
  logic          underrun_set;
  logic [AW:0]   depth_next;

  assign full         = (depth == DEPTH_FULL);
  assign empty        = (depth == '0);
  assign almost_full  = (depth >= af_threshold);
  assign almost_empty = (depth <= ae_threshold);

  // A full FIFO can still accept a push when a pop frees the slot in the same cycle.
  assign push_ok      = push && !flush && (!full || pop);
  assign pop_ok       = pop && !flush && !empty;
  assign overrun_set  = push && !flush && full && !pop;
  assign underrun_set = pop && !flush && empty;
  assign wr_en        = push_ok;

  always_comb begin
    depth_next = depth;
    if (flush)                  depth_next = '0;
    else if (push_ok && !pop_ok) depth_next = depth + (AW + 1)'(1);
    else if (pop_ok && !push_ok) depth_next = depth - (AW + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      depth      <= '0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      high_water <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      end
      depth <= depth_next;

      // A new error in the clearing cycle keeps the flag set.
      if (overrun_set)    overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;
      if (underrun_set)   underrun <= 1'b1;
      else if (err_clear) underrun <= 1'b0;

      if (err_clear)               high_water <= depth;
      else if (depth > high_water) high_water <= depth;
    end
  end

endmodule

// File: rtl/gen_reg_fifo_param.sv
// Parameterised single-clock register-array FIFO with show-ahead or registered
// read, threshold flags, sticky overrun/underrun and an occupancy high-water mark.
module gen_reg_fifo_param
  import gen_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned SHOW_AHEAD = 1,
  parameter int unsigned AW         = clog2(DEPTH)
) (
  input  logic             clockCore,
  input  logic             resetCore,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             pop,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  input  logic [AW:0]      almostFullThreshold,
  input  logic [AW:0]      almostEmptyThreshold,
  input  logic             errClear,
  output logic             full,
  output logic             empty,
  output logic             almostFullFlag,
  output logic             almostEmptyFlag,
  output logic [AW:0]      fifoDepth,
  output logic             overrun,
  output logic             underrun,
  output logic [AW:0]      highWater
);

  logic             wr_en;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  gen_fifo_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctrl (
    .clk          (clockCore),
    .rst_n        (resetCore),
    .flush        (flush),
    .push         (push),
    .pop          (pop),
    .err_clear    (errClear),
    .af_threshold (almostFullThreshold),
    .ae_threshold (almostEmptyThreshold),
    .wr_en        (wr_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .depth        (fifoDepth),
    .full         (full),
    .empty        (empty),
    .almost_full  (almostFullFlag),
    .almost_empty (almostEmptyFlag),
    .overrun      (overrun),
    .underrun     (underrun),
    .high_water   (highWater)
  );

  // Storage is deliberately not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clockCore) begin
    if (wr_en) mem[wr_ptr] <= dataIn;
  end

  if (SHOW_AHEAD != 0) begin : g_show_ahead
    assign dataOut   = empty ? '0 : mem[rd_ptr];
    assign dataValid = !empty;
  end else begin : g_registered
    logic             pop_ok;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign pop_ok = pop && !flush && !empty;

    always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= pop_ok;
        if (pop_ok) data_q <= mem[rd_ptr];
      end
    end

    assign dataOut   = data_q;
    assign dataValid = valid_q;
  end

endmodule

// File: tb/tb_gen_reg_fifo_param.sv
// Directed and randomised checks of gen_reg_fifo_param in show-ahead and
// registered-read configurations against a queue scoreboard.
module tb_gen_reg_fifo_param;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 28;
  localparam int unsigned AW    = 4;

  logic clk;
  logic rst_n;

  logic             a_flush, a_push, a_pop, a_err_clear;
  logic [WIDTH-1:0] a_din, a_dout;
  logic             a_valid, a_full, a_empty, a_af, a_ae, a_overrun, a_underrun;
  logic [AW:0]      a_af_th, a_ae_th, a_depth, a_hw;

  logic             b_flush, b_push, b_pop, b_err_clear;
  logic [WIDTH-1:0] b_din, b_dout;
  logic             b_valid, b_full, b_empty, b_af, b_ae, b_overrun, b_underrun;
  logic [AW:0]      b_af_th, b_ae_th, b_depth, b_hw;

  int unsigned n_pass;
  int unsigned n_total;
  logic [WIDTH-1:0] sb[$];

  gen_reg_fifo_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SHOW_AHEAD(1)) u_dut_sa (
    .clockCore (clk), .resetCore (rst_n), .flush (a_flush), .push (a_push),
    .dataIn (a_din), .pop (a_pop), .dataOut (a_dout), .dataValid (a_valid),
    .almostFullThreshold (a_af_th), .almostEmptyThreshold (a_ae_th),
    .errClear (a_err_clear), .full (a_full), .empty (a_empty),
    .almostFullFlag (a_af), .almostEmptyFlag (a_ae), .fifoDepth (a_depth),
    .overrun (a_overrun), .underrun (a_underrun), .highWater (a_hw)
  );

  gen_reg_fifo_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SHOW_AHEAD(0)) u_dut_reg (
    .clockCore (clk), .resetCore (rst_n), .flush (b_flush), .push (b_push),
    .dataIn (b_din), .pop (b_pop), .dataOut (b_dout), .dataValid (b_valid),
    .almostFullThreshold (b_af_th), .almostEmptyThreshold (b_ae_th),
    .errClear (b_err_clear), .full (b_full), .empty (b_empty),
    .almostFullFlag (b_af), .almostEmptyFlag (b_ae), .fifoDepth (b_depth),
    .overrun (b_overrun), .underrun (b_underrun), .highWater (b_hw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_word;
    logic [WIDTH-1:0] last_word;
    logic             rp, rq, pop_ok, push_ok;

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    {a_flush, a_push, a_pop, a_err_clear} = '0;
    {b_flush, b_push, b_pop, b_err_clear} = '0;
    a_din = '0; b_din = '0;
    a_af_th = 5'd8; a_ae_th = 5'd2;
    b_af_th = 5'd8; b_ae_th = 5'd2;
    exp_word = '0;
    last_word = '0;

    tick(); tick();
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_depth", 32'(a_depth), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_dout", 32'(a_dout), 32'd0);
    chk("rst_overrun", 32'(a_overrun), 32'd0);
    chk("rst_underrun", 32'(a_underrun), 32'd0);
    chk("rst_hw", 32'(a_hw), 32'd0);
    chk("rst_reg_valid", 32'(b_valid), 32'd0);
    chk("rst_reg_dout", 32'(b_dout), 32'd0);
    rst_n = 1'b1;
    tick();

    // Pop on empty, then clear
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    chk("udr_set", 32'(a_underrun), 32'd1);
    chk("udr_depth", 32'(a_depth), 32'd0);
    a_err_clear = 1'b1;
    tick();
    a_err_clear = 1'b0;
    chk("udr_clear", 32'(a_underrun), 32'd0);

    // Push and pop together on empty: push accepted, underrun flagged
    a_push = 1'b1; a_pop = 1'b1; a_din = 28'h0000077;
    tick();
    a_push = 1'b0; a_pop = 1'b0;
    sb.push_back(28'h0000077);
    chk("udr_push_flag", 32'(a_underrun), 32'd1);
    chk("udr_push_depth", 32'(a_depth), 32'd1);
    exp_word = sb.pop_front();
    chk("udr_push_data", 32'(a_dout), 32'(exp_word));
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    a_err_clear = 1'b1;
    tick();
    a_err_clear = 1'b0;
    chk("udr_push_empty", 32'(a_empty), 32'd1);
    chk("clr_hw_zero", 32'(a_hw), 32'd0);

    // Fill, overflow, drain
    for (int i = 1; i <= 16; i++) begin
      a_push = 1'b1; a_din = 28'(i);
      sb.push_back(28'(i));
      tick();
    end
    chk("fill_full", 32'(a_full), 32'd1);
    a_din = 28'hABCDEF0;
    tick();
    a_push = 1'b0;
    chk("ovr_set", 32'(a_overrun), 32'd1);
    chk("ovr_full", 32'(a_full), 32'd1);
    chk("ovr_depth", 32'(a_depth), 32'd16);
    chk("ovr_hw", 32'(a_hw), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_word = sb.pop_front();
      chk("drain_valid", 32'(a_valid), 32'd1);
      chk("drain_data", 32'(a_dout), 32'(exp_word));
      a_pop = 1'b1;
      tick();
    end
    a_pop = 1'b0;
    chk("drain_empty", 32'(a_empty), 32'd1);
    chk("drain_dout_zero", 32'(a_dout), 32'd0);
    a_err_clear = 1'b1;
    tick();
    a_err_clear = 1'b0;
    chk("ovr_clear", 32'(a_overrun), 32'd0);

    // Push+pop while full keeps depth at DEPTH without overrun
    for (int i = 1; i <= 16; i++) begin
      a_push = 1'b1; a_din = 28'(32'h100 + i);
      sb.push_back(28'(32'h100 + i));
      tick();
    end
    exp_word = sb.pop_front();
    chk("full_pp_front", 32'(a_dout), 32'(exp_word));
    a_push = 1'b1; a_pop = 1'b1; a_din = 28'h5555555;
    sb.push_back(28'h5555555);
    tick();
    a_push = 1'b0; a_pop = 1'b0;
    chk("full_pp_depth", 32'(a_depth), 32'd16);
    chk("full_pp_ovr", 32'(a_overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp_word = sb.pop_front();
      chk("full_pp_data", 32'(a_dout), 32'(exp_word));
      a_pop = 1'b1;
      tick();
    end
    a_pop = 1'b0;
    chk("full_pp_last", 32'(exp_word), 32'h5555555);
    a_err_clear = 1'b1;
    tick();
    a_err_clear = 1'b0;

    // Thresholds and flush
    for (int i = 1; i <= 9; i++) begin
      a_push = 1'b1; a_din = 28'(32'h200 + i);
      tick();
    end
    a_push = 1'b0;
    a_af_th = 5'd8; a_ae_th = 5'd2;
    tick();
    chk("thr_depth", 32'(a_depth), 32'd9);
    chk("thr_af", 32'(a_af), 32'd1);
    chk("thr_ae", 32'(a_ae), 32'd0);
    chk("thr_hw", 32'(a_hw), 32'd9);
    a_af_th = 5'd9;
    #1;
    chk("thr_af_eq", 32'(a_af), 32'd1);
    a_af_th = 5'd10;
    #1;
    chk("thr_af_above", 32'(a_af), 32'd0);
    a_af_th = 5'd8;
    a_flush = 1'b1; a_push = 1'b1; a_pop = 1'b1; a_din = 28'hFFFFFFF;
    tick();
    a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0;
    chk("flush_depth", 32'(a_depth), 32'd0);
    chk("flush_empty", 32'(a_empty), 32'd1);
    chk("flush_ae", 32'(a_ae), 32'd1);
    chk("flush_af", 32'(a_af), 32'd0);
    chk("flush_hw", 32'(a_hw), 32'd9);
    chk("flush_valid", 32'(a_valid), 32'd0);
    chk("flush_ovr", 32'(a_overrun), 32'd0);
    chk("flush_udr", 32'(a_underrun), 32'd0);

    // Registered read: data appears one cycle after the accepted pop
    sb.delete();
    b_push = 1'b1; b_din = 28'h1234567;
    tick();
    b_push = 1'b0; b_pop = 1'b1;
    chk("reg_pre_valid", 32'(b_valid), 32'd0);
    tick();
    b_pop = 1'b0;
    chk("reg_valid", 32'(b_valid), 32'd1);
    chk("reg_data", 32'(b_dout), 32'h1234567);
    tick();
    chk("reg_valid_drop", 32'(b_valid), 32'd0);
    chk("reg_data_hold", 32'(b_dout), 32'h1234567);
    last_word = 28'h1234567;

    for (int i = 0; i < 200; i++) begin
      rp = ($urandom_range(0, 99) < 55);
      rq = ($urandom_range(0, 99) < 45);
      b_push = rp; b_pop = rq; b_din = 28'($urandom);
      pop_ok  = rq && (sb.size() > 0);
      push_ok = rp && ((sb.size() < DEPTH) || rq);
      if (pop_ok) exp_word = sb.pop_front();
      if (push_ok) sb.push_back(b_din);
      tick();
      chk("rnd_valid", 32'(b_valid), 32'(pop_ok));
      if (pop_ok) last_word = exp_word;
      chk("rnd_data", 32'(b_dout), 32'(last_word));
      chk("rnd_depth", 32'(b_depth), 32'(sb.size()));
    end
    b_push = 1'b0; b_pop = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
